// File: rtl/btb_predictor_if.sv
// Bundle of the BTB fetch-lookup, EX-update and statistics signals.
//   master : fetch/EX side, drives lookup and update requests, reads predictions and stats
//   slave  : the BTB itself
interface btb_predictor_if;
    // Fetch-stage lookup
    logic        if_valid;
    logic [31:0] if_pc;
    logic        btb_found;
    logic        predict_taken;
    logic [31:0] predict_target;
    // EX-stage resolution / update
    logic        ex_valid;
    logic        ex_is_br;
    logic        ex_is_jump;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_mispredict;
    logic        inv_all;
    // Performance counters
    logic [31:0] stat_lookups;
    logic [31:0] stat_hits;
    logic [31:0] stat_mispredicts;

    modport master (
        output if_valid, if_pc,
        output ex_valid, ex_is_br, ex_is_jump, ex_pc, ex_taken, ex_target, ex_mispredict,
        output inv_all,
        input  btb_found, predict_taken, predict_target,
        input  stat_lookups, stat_hits, stat_mispredicts
    );

    modport slave (
        input  if_valid, if_pc,
        input  ex_valid, ex_is_br, ex_is_jump, ex_pc, ex_taken, ex_target, ex_mispredict,
        input  inv_all,
        output btb_found, predict_taken, predict_target,
        output stat_lookups, stat_hits, stat_mispredicts
    );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational from the fetch PC against registered state; updates from EX are
// applied on the next rising edge. Saturating lookup/hit/mispredict counters are kept.
// Ports:
//   clk_i   : clock, all state changes on the rising edge
//   rst_ni  : synchronous active-low reset
//   bus     : btb_predictor_if.slave (lookup, update, invalidate, statistics)
module btb_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input logic             clk_i,
    input logic             rst_ni,
    btb_predictor_if.slave  bus
);
    localparam int unsigned TagW = 32 - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TagW-1:0]    tag_q    [ENTRIES];
    logic [TagW-1:0]    tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];

    logic [31:0] stat_lookups_q, stat_lookups_d;
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    // Word-offset bits take no part in indexing or tagging.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bus.if_pc[1:0], bus.ex_pc[1:0]};

    // Lookup path
    logic [IDX_W-1:0] lk_idx;
    logic [TagW-1:0]  lk_tag;
    logic             lk_found;
    logic             lk_taken;

    assign lk_idx   = bus.if_pc[IDX_W+1:2];
    assign lk_tag   = bus.if_pc[31:IDX_W+2];
    // Gated by reset so the outputs are quiet while the table contents are undefined.
    assign lk_found = rst_ni && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_found && ctr_q[lk_idx][1];

    assign bus.btb_found      = lk_found;
    assign bus.predict_taken  = lk_taken;
    assign bus.predict_target = lk_taken ? target_q[lk_idx] : bus.if_pc + 32'd4;

    // Update path
    logic [IDX_W-1:0] up_idx;
    logic [TagW-1:0]  up_tag;
    logic             up_en;
    logic             up_hit;

    assign up_idx = bus.ex_pc[IDX_W+1:2];
    assign up_tag = bus.ex_pc[31:IDX_W+2];
    assign up_en  = bus.ex_valid && (bus.ex_is_br || bus.ex_is_jump);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (up_en) begin
            if (up_hit) begin
                if (bus.ex_is_jump) begin
                    ctr_d[up_idx]    = 2'd3;
                    target_d[up_idx] = bus.ex_target;
                end else if (bus.ex_taken) begin
                    ctr_d[up_idx]    = (ctr_q[up_idx] == 2'd3) ? 2'd3 : ctr_q[up_idx] + 2'd1;
                    target_d[up_idx] = bus.ex_target;
                end else begin
                    ctr_d[up_idx]    = (ctr_q[up_idx] == 2'd0) ? 2'd0 : ctr_q[up_idx] - 2'd1;
                end
            end else if (bus.ex_taken || bus.ex_is_jump) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = bus.ex_target;
                ctr_d[up_idx]    = bus.ex_is_jump ? 2'd3 : 2'd2;
            end
        end
        // Invalidation wins over a same-cycle allocation.
        if (bus.inv_all) begin
            valid_d = '0;
        end
    end

    always_comb begin
        stat_lookups_d     = stat_lookups_q;
        stat_hits_d        = stat_hits_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (bus.if_valid && (stat_lookups_q != '1)) begin
            stat_lookups_d = stat_lookups_q + 32'd1;
        end
        if (bus.if_valid && lk_found && (stat_hits_q != '1)) begin
            stat_hits_d = stat_hits_q + 32'd1;
        end
        if (bus.ex_valid && bus.ex_mispredict && (stat_mispredicts_q != '1)) begin
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'd1;
            end
            stat_lookups_q     <= '0;
            stat_hits_q        <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            target_q           <= target_d;
            ctr_q              <= ctr_d;
            stat_lookups_q     <= stat_lookups_d;
            stat_hits_q        <= stat_hits_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign bus.stat_lookups     = stat_lookups_q;
    assign bus.stat_hits        = stat_hits_q;
    assign bus.stat_mispredicts = stat_mispredicts_q;
endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: directed scenarios followed by random traffic.
// The driver computes each cycle's expected lookup result and statistics from a
// behavioural model and queues them; a monitor pops and compares at the falling edge.
module tb_btb_predictor;
    localparam int unsigned Entries = 16;
    localparam int unsigned IdxW    = 4;

    logic clk;
    logic rst_n;
    btb_predictor_if bus_if ();

    btb_predictor #(.ENTRIES(Entries)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          lk_v;
        logic [31:0] pc;
        bit          found;
        bit          taken;
        logic [31:0] tgt;
        bit          chk_s;
        logic [31:0] s_l;
        logic [31:0] s_h;
        logic [31:0] s_m;
    } rec_t;

    rec_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Behavioural model: one slot per index, counters as plain integers.
    bit          m_valid [Entries];
    int unsigned m_tag   [Entries];
    logic [31:0] m_tgt   [Entries];
    int          m_ctr   [Entries];
    logic [31:0] m_look, m_hit, m_mis;
    bit          stats_known = 0;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc >> 2) % Entries;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> (2 + IdxW);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // One clock of stimulus: drive, queue the expectation, then advance the model.
    task automatic cycle(input bit rst, input bit lkv, input logic [31:0] lpc,
                         input bit exv, input bit br, input bit jmp, input logic [31:0] epc,
                         input bit tk, input logic [31:0] etg, input bit mp, input bit inv,
                         input bit preload);
        rec_t r;
        int   i;
        bit   hit;
        @(posedge clk);
        #1;
        if (preload) begin
            force dut.stat_lookups_q = 32'hFFFF_FFFD;
            m_look = 32'hFFFF_FFFD;
        end
        #1;
        if (preload) release dut.stat_lookups_q;
        rst_n                = ~rst;
        bus_if.if_valid      = lkv;
        bus_if.if_pc         = lpc;
        bus_if.ex_valid      = exv;
        bus_if.ex_is_br      = br;
        bus_if.ex_is_jump    = jmp;
        bus_if.ex_pc         = epc;
        bus_if.ex_taken      = tk | jmp;
        bus_if.ex_target     = etg;
        bus_if.ex_mispredict = mp;
        bus_if.inv_all       = inv;

        i       = idx_of(lpc);
        r.lk_v  = lkv;
        r.pc    = lpc;
        r.found = !rst && m_valid[i] && (m_tag[i] == tag_of(lpc));
        r.taken = r.found && (m_ctr[i] >= 2);
        r.tgt   = r.taken ? m_tgt[i] : lpc + 32'd4;
        r.chk_s = stats_known;
        r.s_l   = m_look;
        r.s_h   = m_hit;
        r.s_m   = m_mis;
        exp_q.push_back(r);

        if (rst) begin
            for (int k = 0; k < int'(Entries); k++) begin
                m_valid[k] = 0;
                m_ctr[k]   = 1;
                m_tgt[k]   = 32'd0;
                m_tag[k]   = 0;
            end
            m_look      = 0;
            m_hit       = 0;
            m_mis       = 0;
            stats_known = 1;
        end else begin
            if (lkv) m_look = sat_inc(m_look);
            if (lkv && r.found) m_hit = sat_inc(m_hit);
            if (exv && mp) m_mis = sat_inc(m_mis);
            if (exv && (br || jmp)) begin
                i   = idx_of(epc);
                hit = m_valid[i] && (m_tag[i] == tag_of(epc));
                if (hit) begin
                    if (jmp) begin
                        m_ctr[i] = 3;
                        m_tgt[i] = etg;
                    end else if (tk) begin
                        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                        m_tgt[i] = etg;
                    end else begin
                        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
                    end
                end else if (tk || jmp) begin
                    m_valid[i] = 1;
                    m_tag[i]   = tag_of(epc);
                    m_tgt[i]   = etg;
                    m_ctr[i]   = jmp ? 3 : 2;
                end
            end
            if (inv) begin
                for (int k = 0; k < int'(Entries); k++) m_valid[k] = 0;
            end
        end
    endtask

    // Shorthands
    task automatic look(input logic [31:0] pc);
        cycle(0, 1, pc, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input bit lkv, input logic [31:0] lpc, input bit br, input bit jmp,
                       input logic [31:0] epc, input bit tk, input logic [31:0] etg);
        cycle(0, lkv, lpc, 1, br, jmp, epc, tk, etg, 0, 0, 0);
    endtask

    // Monitor
    always @(negedge clk) begin
        rec_t r;
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            if (r.lk_v) begin
                chk($sformatf("btb_found@%h", r.pc), {31'd0, bus_if.btb_found}, {31'd0, r.found});
                chk($sformatf("predict_taken@%h", r.pc), {31'd0, bus_if.predict_taken},
                    {31'd0, r.taken});
                chk($sformatf("predict_target@%h", r.pc), bus_if.predict_target, r.tgt);
            end
            if (r.chk_s) begin
                chk("stat_lookups", bus_if.stat_lookups, r.s_l);
                chk("stat_hits", bus_if.stat_hits, r.s_h);
                chk("stat_mispredicts", bus_if.stat_mispredicts, r.s_m);
            end
        end
    end

    initial begin
        rst_n                = 1'b0;
        bus_if.if_valid      = 1'b0;
        bus_if.if_pc         = '0;
        bus_if.ex_valid      = 1'b0;
        bus_if.ex_is_br      = 1'b0;
        bus_if.ex_is_jump    = 1'b0;
        bus_if.ex_pc         = '0;
        bus_if.ex_taken      = 1'b0;
        bus_if.ex_target     = '0;
        bus_if.ex_mispredict = 1'b0;
        bus_if.inv_all       = 1'b0;
        m_look = 0;
        m_hit  = 0;
        m_mis  = 0;

        // Reset, cold miss, allocate
        cycle(1, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        look(32'h100);
        upd(0, 0, 1, 0, 32'h100, 1, 32'h80);
        look(32'h100);
        // Counter saturation: three not-taken then two taken, looking up every cycle
        repeat (3) upd(1, 32'h100, 1, 0, 32'h100, 0, 32'h0);
        repeat (2) upd(1, 32'h100, 1, 0, 32'h100, 1, 32'h80);
        look(32'h100);
        // Not-taken miss and aliasing
        upd(0, 0, 1, 0, 32'h200, 0, 32'h999);
        look(32'h200);
        upd(0, 0, 1, 0, 32'h100, 1, 32'h80);
        upd(0, 0, 1, 0, 32'h140, 1, 32'h180);
        look(32'h100);
        look(32'h140);
        // Same-cycle collision
        upd(0, 0, 1, 0, 32'h100, 1, 32'h80);
        upd(1, 32'h100, 1, 0, 32'h100, 1, 32'h300);
        look(32'h100);
        // inv_all with concurrent jump update
        upd(0, 0, 0, 1, 32'h10C, 1, 32'h500);
        look(32'h10C);
        cycle(0, 0, 0, 1, 0, 1, 32'h400, 1, 32'h440, 0, 1, 0);
        look(32'h400);
        look(32'h100);
        look(32'h10C);
        // Stats: 5 lookups, 2 hits, 3 mispredicts after a fresh reset
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        upd(0, 0, 0, 1, 32'h100, 1, 32'h700);
        cycle(0, 1, 32'h100, 1, 0, 0, 32'h0, 0, 0, 1, 0, 0);
        cycle(0, 1, 32'h100, 1, 0, 0, 32'h0, 0, 0, 1, 0, 0);
        cycle(0, 1, 32'h104, 1, 0, 0, 32'h0, 0, 0, 1, 0, 0);
        look(32'h108);
        look(32'h10C);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Saturation of stat_lookups
        cycle(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (4) look(32'h100);
        // Reset mid-stream drops the concurrent update
        cycle(1, 1, 32'h100, 1, 1, 0, 32'h180, 1, 32'h40, 1, 0, 0);
        look(32'h100);
        look(32'h180);

        // Random traffic over a small PC pool to provoke hits and aliasing
        for (int n = 0; n < 600; n++) begin
            bit          rst, lkv, exv, br, jmp, tk, mp, inv;
            int unsigned kind;
            logic [31:0] lpc, epc, etg;
            rst  = ($urandom_range(0, 99) < 1);
            lkv  = ($urandom_range(0, 99) < 80);
            exv  = ($urandom_range(0, 99) < 70);
            kind = $urandom_range(0, 2);
            br   = (kind == 0);
            jmp  = (kind == 1);
            tk   = ($urandom_range(0, 1) == 1);
            mp   = ($urandom_range(0, 99) < 20);
            inv  = ($urandom_range(0, 99) < 2);
            lpc  = {$urandom_range(0, 127), 2'b00} | $urandom_range(0, 3);
            epc  = {$urandom_range(0, 127), 2'b00};
            etg  = {$urandom, 2'b00};
            cycle(rst, lkv, lpc, exv, br, jmp, epc, tk, etg, mp, inv, 0);
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
